// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for the EX stage.
// Produces {remainder, quotient} after WIDTH iterations and stalls the pipeline meanwhile.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic               op1_neg;
    logic               op2_neg;

    // Handshake: EX holds start_i (and operands) high until it sees ready_o; while the
    // request is pending and not flushed, stall_req_o freezes EX and earlier stages.
    assign stall_req_o = start_i & ~ready_q & ~annul_i;
    assign result_o    = result_q;
    assign ready_o     = ready_q;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // The trial subtraction is one bit wider than the operands so that a partial
    // remainder with its MSB set still compares correctly against large divisors.
    always_comb begin
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        no_borrow = ~diff[WIDTH];
        rem_d     = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], no_borrow};
        quo_fix   = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
        rem_fix   = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q   <= S_ON;
                            dvd_q     <= op1_mag;
                            dvs_q     <= op2_mag;
                            neg_quo_q <= op1_neg ^ op2_neg;
                            neg_rem_q <= op1_neg;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                    end else begin
                        state_q  <= S_END;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q  <= S_END;
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

endmodule
